// File: rtl/jk_reg_sequencer.sv
// rtl/jk_reg_sequencer.sv - command sequencer driving a WIDTH-bit J-K flip-flop bank
// Optional abort input is enabled by defining JK_SEQ_ABORT_EN.
module jk_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef JK_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_SET    = 3'b011;
  localparam logic [2:0] OP_TOGGLE = 3'b100;
  localparam logic [2:0] OP_CNT_UP = 3'b101;
  localparam logic [2:0] OP_CNT_DN = 3'b110;
  localparam logic [2:0] OP_SHIFT  = 3'b111;

  localparam logic [WIDTH-1:0] Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_q;
  logic [2:0]       r_op;
  logic             r_sin;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  logic             w_accept;
  logic             w_multi;
  logic             w_enter_run;
  logic             w_abort;
  logic             w_step;
  logic             w_step_wrap;
  logic [WIDTH-1:0] w_step_val;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

`ifdef JK_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_multi     = (cmd_op == OP_CNT_UP) || (cmd_op == OP_CNT_DN) || (cmd_op == OP_SHIFT);
  assign w_enter_run = w_accept && w_multi && (cmd_count != '0);
  assign w_step      = (r_state == S_RUN) && !w_abort;

  // Next bank value for a count/shift step; the bank itself only sees J/K.
  always_comb begin
    w_step_val = r_q;
    case (r_op)
      OP_CNT_UP: w_step_val = r_q + Q_ONE;
      OP_CNT_DN: w_step_val = r_q - Q_ONE;
      default:   w_step_val = {r_q[WIDTH-2:0], r_sin};
    endcase
  end

  assign w_step_wrap = w_step &&
                       (((r_op == OP_CNT_UP) && (&r_q)) ||
                        ((r_op == OP_CNT_DN) && (r_q == '0)));

  always_comb begin
    w_j = '0;
    w_k = '0;
    if (w_accept && !w_multi) begin
      case (cmd_op)
        OP_LOAD: begin
          w_j = cmd_data;
          w_k = ~cmd_data;
        end
        OP_CLEAR:  w_k = cmd_data;
        OP_SET:    w_j = cmd_data;
        OP_TOGGLE: begin
          w_j = cmd_data;
          w_k = cmd_data;
        end
        default: begin
          w_j = '0;
          w_k = '0;
        end
      endcase
    end else if (w_step) begin
      w_j = w_step_val & ~r_q;
      w_k = ~w_step_val & r_q;
    end
  end

  // J-K bank: 00 hold, 01 clear, 10 set, 11 toggle, applied bitwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= (w_j & ~r_q) | (~w_k & r_q);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_enter_run ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_abort || (r_cnt == '0)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op   <= OP_NOP;
      r_sin  <= 1'b0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step_wrap;
      if (w_enter_run) begin
        r_op  <= cmd_op;
        r_sin <= cmd_data[0];
        r_cnt <= cmd_count - CNT_ONE;
      end else if (w_step && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign q         = r_q;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign wrap      = r_wrap;

endmodule
